parity_pkt_sched: RTL and testbench
===================================

// Module: parity_pkt_sched
// PURPOSE
//   Shares one 64-bit XOR-reduction parity engine between NREQ requesters, at
//   packet granularity. Round-robin arbitration; the grant is held until the
//   winner's last beat. Per-packet parity is accumulated over all beats and
//   returned with the requester id and beat count through a ready/valid port.
//   Sits between the DMA/bus clients and the parity engine.
// PARAMETERS
//   NREQ    4    number of requesters (2..8)
//   DW      64   data beat width
//   IDW     2    id width, = clog2(NREQ)
//   TO_CYC  255  stall-timeout threshold in cycles (PARITY_TIMEOUT_EN only)
// PORTS
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req_valid    in   NREQ     beat valid, one bit per requester
//   req_data     in   NREQ*DW  beat data; requester i at [i*DW +: DW]
//   req_last     in   NREQ     last beat of packet, one bit per requester
//   req_ready    out  NREQ     beat accepted when req_valid[i] & req_ready[i]
//   res_valid    out  1        result available
//   res_ready    in   1        result consumed when res_valid & res_ready
//   res_id       out  IDW      requester that owns the result
//   res_parity   out  1        XOR of every bit of every accepted beat (even parity)
//   res_words    out  16       accepted beat count, saturates at 16'hFFFF
//   res_timeout  out  1        packet ended by stall timeout
//   busy         out  1        FSM not in IDLE
// BEHAVIOUR
// - Reset: FSM=IDLE, rr_ptr=0, acc=0, cnt=0. All outputs 0: req_ready,
//   res_valid, res_id, res_parity, res_words, res_timeout, busy.
// - FSM IDLE -> BUSY -> RESULT -> IDLE. Only the registered state drives outputs.
// - IDLE: if any req_valid, grant g = first set bit searching upward from
//   rr_ptr, wrapping modulo NREQ. Latch g, clear acc and cnt, go to BUSY.
//   No beat is accepted in IDLE, so every packet pays a 1-cycle arbitration bubble.
// - BUSY: req_ready = one-hot(g); all other bits are 0.
//   On each accept: acc ^= ^req_data[g]; cnt increments, saturating.
//   Accept with req_last[g]=1: load res_parity = acc ^ ^beat, res_words = cnt+1
//   (saturated), res_id = g; go to RESULT. res_valid=1 the next cycle.
//   Latency from last-beat accept to res_valid: 1 cycle.
// - RESULT: req_ready=0. Result outputs stay stable while res_valid=1 and
//   res_ready=0.
//   When res_ready=1: res_valid drops next cycle, rr_ptr = (g+1) mod NREQ,
//   go to IDLE. res_ready=1 on the first RESULT cycle is legal; result is
//   consumed in 1 cycle.
// - One result outstanding at a most; a full result stalls all requesters.
// - req_valid on non-granted requesters is ignored while BUSY. Those requesters
//   must hold valid; there is no starvation, by rotation.
// - A single-beat packet (valid & last on the first accept) is legal:
//   res_words=1.
// - rst_n asserted mid-packet or mid-result: the packet and result are
//   dropped, everything returns to reset values, and rr_ptr returns to 0.
// - busy = (state != IDLE).
// CONFIGURATION
// - PARITY_TIMEOUT_EN defined: in BUSY, a stall counter counts consecutive
//   cycles with req_valid[g]=0 and clears on any accept.
//   When it reaches TO_CYC, go to RESULT with res_timeout=1 and
//   res_parity/res_words = state so far (possibly 0 beats). The stall counter
//   clears on entry to IDLE.
// - PARITY_TIMEOUT_EN undefined: no stall counter, res_timeout tied to 0,
//   a granted packet waits indefinitely, TO_CYC unused.
// TESTING
// - Req0, 1 beat 64'h1, last -> res_valid 2 cycles after IDLE; id=0, parity=1, words=1.
// - Req2, beats 64'h3, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF (last) -> parity=1, words=3.
// - Req0..3 all valid, single beats, res_ready=1 -> grant order 0,1,2,3,0.
// - res_ready=0 for 10 cycles after result -> res_* stable, req_ready=0,
//   pending requester not accepted.
// - Reset pulse during beat 2 of a 4-beat packet -> all outputs 0 and the
//   next grant starts from requester 0.
// - PARITY_TIMEOUT_EN, TO_CYC=8: req1 sends 1 beat 64'h1 then drops valid
//   -> after 8 idle cycles, res_timeout=1, parity=1, words=1, id=1.

Source files
------------

// File: rtl/parity_pkt_sched_if.sv
// Request/result bundle for the shared parity engine scheduler.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1. A source holds valid (and its payload) stable until that edge; ready
// may rise or fall freely and never depends combinationally on valid.
interface parity_pkt_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [IDW-1:0]     res_id;
  logic               res_parity;
  logic [15:0]        res_words;
  logic               res_timeout;
  logic               busy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, req_last, res_ready,
    output req_ready, res_valid, res_id, res_parity, res_words, res_timeout, busy
  );

  // Requester/consumer side.
  modport master (
    output req_valid, req_data, req_last, res_ready,
    input  req_ready, res_valid, res_id, res_parity, res_words, res_timeout, busy
  );
endinterface

// File: rtl/parity_pkt_sched.sv
// Packet-granular round-robin scheduler in front of one XOR-reduction parity
// engine. A winner keeps the grant until its last beat; the packet parity,
// beat count and owner id are then held on the result port until consumed.
// Optional stall timeout: define PARITY_TIMEOUT_EN to end a granted packet
// after TO_CYC consecutive cycles without a beat.
module parity_pkt_sched #(
  parameter int NREQ   = 4,
  parameter int DW     = 64,
  parameter int IDW    = 2,
  parameter int TO_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  parity_pkt_sched_if.slave   bus,
  output logic [1:0]          o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_grant, r_rr_ptr, w_pick;
  logic [IDW:0]   w_idx;
  logic           r_acc;
  logic [15:0]    r_cnt, w_cnt_inc;
  logic           r_res_parity;
  logic [15:0]    r_res_words;
  logic [IDW-1:0] r_res_id;
  logic           w_load, w_accept, w_finish, w_consume;
  logic           w_g_valid, w_g_last, w_beat_par;
  logic [DW-1:0]  w_g_data;
`ifdef PARITY_TIMEOUT_EN
  logic [15:0]    r_stall;
  logic           r_res_timeout;
  logic           w_timeout;
`else
  logic           w_unused_to;
`endif

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  // Walk offsets high to low so the smallest offset is the one that sticks.
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) w_idx = w_idx - (IDW+1)'(NREQ);
      if (bus.req_valid[w_idx[IDW-1:0]]) w_pick = w_idx[IDW-1:0];
    end
  end

  // Select the granted requester's beat signals.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_g_valid = bus.req_valid[i];
        w_g_last  = bus.req_last[i];
        w_g_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign w_beat_par = ^w_g_data;
  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_consume   = 1'b0;
`ifdef PARITY_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_accept = w_g_valid;
        if (w_g_valid && w_g_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_RESULT;
        end
`ifdef PARITY_TIMEOUT_EN
        else if (!w_g_valid && (r_stall == 16'(TO_CYC - 1))) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESULT;
        end
`endif
      end
      S_RESULT: begin
        if (bus.res_ready) begin
          w_consume   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, grant, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_acc        <= 1'b0;
      r_cnt        <= '0;
      r_res_parity <= 1'b0;
      r_res_words  <= '0;
      r_res_id     <= '0;
`ifdef PARITY_TIMEOUT_EN
      r_res_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_grant <= w_pick;
        r_acc   <= 1'b0;
        r_cnt   <= '0;
      end
      if (w_accept) begin
        r_acc <= r_acc ^ w_beat_par;
        r_cnt <= w_cnt_inc;
      end
      if (w_finish) begin
        r_res_parity <= r_acc ^ w_beat_par;
        r_res_words  <= w_cnt_inc;
        r_res_id     <= r_grant;
`ifdef PARITY_TIMEOUT_EN
        r_res_timeout <= 1'b0;
`endif
      end
`ifdef PARITY_TIMEOUT_EN
      if (w_timeout) begin
        r_res_parity  <= r_acc;
        r_res_words   <= r_cnt;
        r_res_id      <= r_grant;
        r_res_timeout <= 1'b1;
      end
`endif
      if (w_consume) begin
        r_rr_ptr <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

`ifdef PARITY_TIMEOUT_EN
  // Consecutive no-beat cycles of the granted requester; zero outside BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if ((r_state == S_BUSY) && !w_g_valid) begin
      r_stall <= r_stall + 16'd1;
    end else begin
      r_stall <= '0;
    end
  end

  assign bus.res_timeout = r_res_timeout;
`else
  assign w_unused_to     = (TO_CYC == 0);
  assign bus.res_timeout = 1'b0;
`endif

  // Only the granted requester sees ready, and only while BUSY.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = (r_state == S_BUSY) && (r_grant == IDW'(i));
    end
  end

  assign bus.res_valid  = (r_state == S_RESULT);
  assign bus.res_id     = r_res_id;
  assign bus.res_parity = r_res_parity;
  assign bus.res_words  = r_res_words;
  assign bus.busy       = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_parity_pkt_sched.sv
// Directed bench for parity_pkt_sched: reset values, single/multi-beat
// packets, round-robin order, result back-pressure, mid-packet reset and
// (with PARITY_TIMEOUT_EN) the stall timeout.
module tb_parity_pkt_sched;
  localparam int NREQ   = 4;
  localparam int DW     = 64;
  localparam int IDW    = 2;
  localparam int TO_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [19:0] exp_q[$];

  parity_pkt_sched_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus();

  parity_pkt_sched #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .TO_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock and global time guard.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pack(input logic [1:0] id, input logic par,
                                       input logic [15:0] words, input logic to);
    return {id, par, words, to};
  endfunction

  task automatic set_beat(input int id, input logic [63:0] d, input logic last, input logic v);
    bus.req_valid[id]          = v;
    bus.req_data[id*DW +: DW]  = d;
    bus.req_last[id]           = last;
  endtask

  // Driver: present n beats on requester id, each held until accepted.
  // Call at a negedge; returns at a negedge with valid dropped.
  task automatic send_pkt(input int id, input int n, input logic [63:0] d0,
                          input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d;
    for (int b = 0; b < n; b++) begin
      d = (b == 0) ? d0 : (b == 1) ? d1 : (b == 2) ? d2 : d3;
      set_beat(id, d, (b == n - 1), 1'b1);
      for (int g = 0; g < 300 && !bus.req_ready[id]; g++) @(negedge clk);
      check_eq($sformatf("r%0d_ready_b%0d", id, b), bus.req_ready[id], 1);
      @(negedge clk);
    end
    set_beat(id, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0 && !bus.busy && bus.req_valid == '0) break;
      @(negedge clk);
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    check_eq({tag, "_idle"}, bus.busy, 0);
  endtask

  // Scoreboard: every consumed result is compared with the head of exp_q.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.res_valid && bus.res_ready) begin
        check_eq("res_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check_eq("res", pack(bus.res_id, bus.res_parity, bus.res_words, bus.res_timeout),
                   exp_q.pop_front());
      end
    end
  end

  // Directed sequence.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_res_id", bus.res_id, 0);
    check_eq("rst_res_parity", bus.res_parity, 0);
    check_eq("rst_res_words", bus.res_words, 0);
    check_eq("rst_res_timeout", bus.res_timeout, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: req0 single beat 1, result two cycles after leaving IDLE.
    bus.res_ready = 1'b1;
    exp_q.push_back(pack(2'd0, 1'b1, 16'd1, 1'b0));
    set_beat(0, 64'h1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("t1_grant", bus.req_ready, 4'b0001);
    check_eq("t1_busy", bus.busy, 1);
    check_eq("t1_res_valid_c1", bus.res_valid, 0);
    @(negedge clk);
    set_beat(0, '0, 1'b0, 1'b0);
    check_eq("t1_res_valid_c2", bus.res_valid, 1);
    check_eq("t1_ready_in_result", bus.req_ready, 0);
    wait_idle("t1");

    // T2: req2, three beats, parity 0^1^0 = 1.
    exp_q.push_back(pack(2'd2, 1'b1, 16'd3, 1'b0));
    send_pkt(2, 3, 64'h3, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    wait_idle("t2");

    // T3: reset during beat 2 of a 4-beat packet from req3.
    set_beat(3, 64'h1, 1'b0, 1'b1);
    for (int g = 0; g < 50 && !bus.req_ready[3]; g++) @(negedge clk);
    check_eq("t3_grant", bus.req_ready, 4'b1000);
    @(negedge clk);
    set_beat(3, 64'h1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t3_req_ready", bus.req_ready, 0);
    check_eq("t3_res_valid", bus.res_valid, 0);
    check_eq("t3_res_id", bus.res_id, 0);
    check_eq("t3_res_parity", bus.res_parity, 0);
    check_eq("t3_res_words", bus.res_words, 0);
    check_eq("t3_res_timeout", bus.res_timeout, 0);
    check_eq("t3_busy", bus.busy, 0);
    set_beat(3, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T4: all requesters valid; order must restart at 0: 0,1,2,3,0.
    exp_q.push_back(pack(2'd0, 1'b1, 16'd1, 1'b0));
    exp_q.push_back(pack(2'd1, 1'b0, 16'd1, 1'b0));
    exp_q.push_back(pack(2'd2, 1'b1, 16'd1, 1'b0));
    exp_q.push_back(pack(2'd3, 1'b0, 16'd1, 1'b0));
    exp_q.push_back(pack(2'd0, 1'b1, 16'd1, 1'b0));
    fork
      begin
        send_pkt(0, 1, 64'h1, 64'h0, 64'h0, 64'h0);
        send_pkt(0, 1, 64'hFF00_0000_0000_0001, 64'h0, 64'h0, 64'h0);
      end
      send_pkt(1, 1, 64'h3, 64'h0, 64'h0, 64'h0);
      send_pkt(2, 1, 64'h7, 64'h0, 64'h0, 64'h0);
      send_pkt(3, 1, 64'hF0, 64'h0, 64'h0, 64'h0);
    join
    wait_idle("t4");

    // T5: result held 10 cycles; req3 pending must not be accepted.
    bus.res_ready = 1'b0;
    exp_q.push_back(pack(2'd1, 1'b1, 16'd1, 1'b0));
    exp_q.push_back(pack(2'd3, 1'b0, 16'd2, 1'b0));
    fork
      send_pkt(1, 1, 64'h7, 64'h0, 64'h0, 64'h0);
      send_pkt(3, 2, 64'h1, 64'h1, 64'h0, 64'h0);
    join_none
    for (int c = 0; c < 50 && !bus.res_valid; c++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check_eq("t5_res_valid", bus.res_valid, 1);
      check_eq("t5_res_id", bus.res_id, 1);
      check_eq("t5_res_parity", bus.res_parity, 1);
      check_eq("t5_res_words", bus.res_words, 1);
      check_eq("t5_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    wait_idle("t5");

`ifdef PARITY_TIMEOUT_EN
    // T6: req1 sends one non-last beat then stalls until timeout.
    exp_q.push_back(pack(2'd1, 1'b1, 16'd1, 1'b1));
    set_beat(1, 64'h1, 1'b0, 1'b1);
    for (int g = 0; g < 50 && !bus.req_ready[1]; g++) @(negedge clk);
    check_eq("t6_grant", bus.req_ready, 4'b0010);
    @(negedge clk);
    set_beat(1, '0, 1'b0, 1'b0);
    wait_idle("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
